// File: rtl/crypt_pkg.sv
// Shared types, constants and helpers for the program-1 encryption sequencer.
package crypt_pkg;

  // Memory map of the job
  localparam logic [7:0] PRE_ADDR  = 8'd41;
  localparam logic [7:0] TAP_ADDR  = 8'd42;
  localparam logic [7:0] SEED_ADDR = 8'd43;
  localparam logic [7:0] OUT_BASE  = 8'd64;
  localparam logic [7:0] OUT_LEN   = 8'd64;
  localparam logic [8:0] MSG_LEN   = 9'd41;
  localparam logic [7:0] PAD_CHAR  = 8'h20;

  typedef enum logic [2:0] {
    ST_P0   = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_B_RD = 3'd4,
    ST_B_WR = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // Fibonacci step: shift left, feed back the parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] state, input logic [7:0] tap);
    return {state[6:0], ^(state & tap)};
  endfunction

  // Stream position is padding when it precedes the preamble end or lies past
  // the message; the subtraction is done in 9 bits so large pre never wraps.
  function automatic logic is_pad(input logic [7:0] idx, input logic [7:0] pre);
    logic [8:0] off;
    off = {1'b0, idx} - {1'b0, pre};
    return (idx < pre) || (off >= MSG_LEN);
  endfunction

endpackage

// File: rtl/crypt_seq_ctrl_if.sv
// Data-memory port shared between the sequencer (master) and the memory (slave).
interface crypt_seq_ctrl_if;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with seed load and step enable.
module lfsr8
  import crypt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_seed,
  input  logic       i_step,
  input  logic [7:0] i_tap,
  output logic [7:0] o_q
);

  logic [7:0] r_q;

  // State register: clear on reset, load has priority over stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 8'h00;
    end else if (i_load) begin
      r_q <= i_seed;
    end else if (i_step) begin
      r_q <= lfsr_next(r_q, i_tap);
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/crypt_seq_ctrl.sv
// Program-1 encryption sequencer: fetches parameters, streams the padded
// message through the LFSR keystream and writes 64 ciphertext bytes.
module crypt_seq_ctrl
  import crypt_pkg::*;
(
  input  logic              clk,
  input  logic              init,
  crypt_seq_ctrl_if.master  mem,
  output logic              done
);

  state_t     r_state;
  logic [7:0] r_pre;
  logic [7:0] r_tap;
  logic [7:0] r_idx;
  logic       r_done;

  logic [7:0] w_lfsr;
  logic       w_pad;
  logic       w_rd;
  logic       w_wr;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;

  assign w_pad = is_pad(r_idx, r_pre);

  // Keystream generator: seeded in P3, advanced once per written byte.
  lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (init),
    .i_load (r_state == ST_P3),
    .i_seed (mem.mem_rdata),
    .i_step (r_state == ST_B_WR),
    .i_tap  (r_tap),
    .o_q    (w_lfsr)
  );

  // Sequencer FSM: parameter fetch, then alternating read/write per byte.
  always_ff @(posedge clk) begin
    if (init) begin
      r_state <= ST_P0;
      r_pre   <= 8'h00;
      r_tap   <= 8'h00;
      r_idx   <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_P0: r_state <= ST_P1;
        ST_P1: begin
          r_pre   <= mem.mem_rdata;
          r_state <= ST_P2;
        end
        ST_P2: begin
          r_tap   <= mem.mem_rdata;
          r_state <= ST_P3;
        end
        ST_P3: begin
          r_idx   <= 8'h00;
          r_state <= ST_B_RD;
        end
        ST_B_RD: r_state <= ST_B_WR;
        ST_B_WR: begin
          r_idx <= r_idx + 8'd1;
          if (r_idx == (OUT_LEN - 8'd1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_B_RD;
          end
        end
        ST_DONE: r_done <= 1'b1;
        default: begin
          r_state <= ST_P0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Memory port decode from the current state and stream index.
  always_comb begin
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = 8'h00;
    w_wdata = 8'h00;
    case (r_state)
      ST_P0: begin
        w_rd   = 1'b1;
        w_addr = PRE_ADDR;
      end
      ST_P1: begin
        w_rd   = 1'b1;
        w_addr = TAP_ADDR;
      end
      ST_P2: begin
        w_rd   = 1'b1;
        w_addr = SEED_ADDR;
      end
      ST_B_RD: begin
        w_rd   = ~w_pad;
        w_addr = r_idx - r_pre;
      end
      ST_B_WR: begin
        w_wr    = 1'b1;
        w_addr  = OUT_BASE + r_idx;
        w_wdata = (w_pad ? PAD_CHAR : mem.mem_rdata) ^ w_lfsr;
      end
      default: begin
        w_rd = 1'b0;
      end
    endcase
  end

  // No memory traffic at all while init is held, even mid-job.
  assign mem.mem_rd_en = w_rd & ~init;
  assign mem.mem_wr_en = w_wr & ~init;
  assign mem.mem_addr  = init ? 8'h00 : w_addr;
  assign mem.mem_wdata = init ? 8'h00 : w_wdata;
  assign done          = r_done;

endmodule

// File: tb/tb_crypt_seq_ctrl.sv
// Self-checking bench for crypt_seq_ctrl with a behavioural memory and model.
module tb_crypt_seq_ctrl;

  logic clk;
  logic init;
  logic done;
  logic ld_all;

  logic [7:0] dm  [256];
  logic [7:0] img [256];
  logic [7:0] m   [41];
  int         exp_ct [64];

  int n_vec;
  int n_err;
  int n_stray;
  int n_gate;
  int n_rd_hi;
  int n_strb;

  crypt_seq_ctrl_if mem_if ();

  crypt_seq_ctrl u_dut (
    .clk  (clk),
    .init (init),
    .mem  (mem_if),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with 1-cycle read latency plus traffic monitors.
  always @(posedge clk) begin
    if (ld_all) begin
      dm <= img;
    end else if (mem_if.mem_wr_en) begin
      dm[mem_if.mem_addr] <= mem_if.mem_wdata;
    end
    if (mem_if.mem_rd_en) mem_if.mem_rdata <= dm[mem_if.mem_addr];
    if (mem_if.mem_wr_en && (mem_if.mem_addr < 8'd64 || mem_if.mem_addr > 8'd127))
      n_stray <= n_stray + 1;
    if (init && (mem_if.mem_rd_en || mem_if.mem_wr_en)) n_gate <= n_gate + 1;
    if (mem_if.mem_rd_en && mem_if.mem_addr >= 8'd34 && mem_if.mem_addr <= 8'd40)
      n_rd_hi <= n_rd_hi + 1;
    if (mem_if.mem_rd_en || mem_if.mem_wr_en) n_strb <= n_strb + 1;
  end

  task automatic chk(input string tag, input int got, input int expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Reference: padded stream XOR keystream, keystream via parity feedback.
  task automatic build_model(input int pre, input int tap, input int seed, output int rd_hi);
    int s;
    int j;
    int b;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      j = i - pre;
      b = (j < 0 || j >= 41) ? 32'h20 : int'(m[j]);
      exp_ct[i] = b ^ s;
      s = (s * 2 + ($countones(s & tap) % 2)) % 256;
    end
    rd_hi = 0;
    for (int k = 34; k <= 40; k++) if (k + pre <= 63) rd_hi++;
  endtask

  task automatic run_job(input int pre, input int tap, input int seed, input int pulse);
    int cyc;
    int total;
    int got;
    int pend;
    int rd0;
    int st0;
    int gt0;
    int rd_hi_exp;
    init = 1'b1;
    for (int k = 0; k < 256; k++) img[k] = 8'($urandom);
    for (int k = 0; k < 41; k++) img[k] = m[k];
    img[41] = 8'(pre);
    img[42] = 8'(tap);
    img[43] = 8'(seed);
    @(posedge clk); #1 ld_all = 1'b1;
    @(posedge clk); #1 ld_all = 1'b0;
    build_model(pre, tap, seed, rd_hi_exp);
    rd0 = n_rd_hi;
    st0 = n_stray;
    gt0 = n_gate;
    pend = pulse;
    init = 1'b0;
    cyc = 0;
    total = 0;
    got = -1;
    while (total < 400 && got < 0) begin
      @(posedge clk); #1;
      cyc++;
      total++;
      if (done) got = cyc;
      if (pend > 0 && cyc == pend - 1) begin
        init = 1'b1;
      end else if (pend > 0 && cyc == pend) begin
        init = 1'b0;
        cyc = 0;
        pend = 0;
      end
    end
    chk("done_latency", got, 132);
    for (int i = 0; i < 64; i++) chk("ciphertext", int'(dm[64 + i]), exp_ct[i]);
    chk("stray_writes", n_stray - st0, 0);
    chk("strobe_in_init", n_gate - gt0, 0);
    if (pulse == 0) chk("msg_tail_reads", n_rd_hi - rd0, rd_hi_exp);
  endtask

  initial begin
    string msg;
    int lo;
    int s0;
    msg = "Mr. Watson, come here. I want to see you.";
    n_vec = 0;
    n_err = 0;
    n_stray = 0;
    n_gate = 0;
    n_rd_hi = 0;
    n_strb = 0;
    ld_all = 1'b0;
    init = 1'b1;
    for (int k = 0; k < 41; k++) m[k] = msg[k];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(mem_if.mem_rd_en), 0);
    chk("rst_wr_en", int'(mem_if.mem_wr_en), 0);
    chk("rst_addr", int'(mem_if.mem_addr), 0);
    chk("rst_wdata", int'(mem_if.mem_wdata), 0);

    // Reference message, known keystream start
    run_job(9, 32'he1, 32'h01, 0);
    chk("dm64", int'(dm[64]), 32'h21);
    chk("dm65", int'(dm[65]), 32'h23);
    chk("dm66", int'(dm[66]), 32'h27);

    // Last message byte lands exactly on idx 63, then truncation
    run_job(23, int'($urandom_range(0, 255)), int'($urandom_range(1, 255)), 0);
    run_job(30, int'($urandom_range(0, 255)), int'($urandom_range(1, 255)), 0);

    // Zero seed: output is the padded plaintext
    run_job(9, int'($urandom_range(0, 255)), 0, 0);
    chk("seed0_M", int'(dm[73]), 32'h4d);

    // Abort mid-job and restart
    run_job(9, int'($urandom_range(0, 255)), int'($urandom_range(1, 255)), 60);

    // Random messages and parameters, including pre beyond the stream
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 41; k++) m[k] = 8'($urandom);
      run_job(int'($urandom_range(0, 90)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), 0);
    end
    run_job(200, int'($urandom_range(0, 255)), int'($urandom_range(1, 255)), 0);

    // done holds with no traffic, then clears on init
    lo = 0;
    s0 = n_strb;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (!done) lo++;
    end
    chk("done_hold_low", lo, 0);
    chk("done_hold_strobes", n_strb - s0, 0);
    init = 1'b1;
    @(posedge clk); #1;
    chk("done_clear", int'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crypt_seq_ctrl.md
Name: crypt_seq_ctrl

Overview:
Hardware sequencer for the program-1 encryption job. It runs the same job the ISA program runs, so the bench can compare a software result against it.
- Reads the message and its parameters from the 256-byte data memory.
- Builds the space-padded 64-byte stream, XORs each byte with an 8-bit Fibonacci LFSR state and writes the ciphertext to DM[64:127].
- Raises done when finished.
- Sits beside the core on the data_mem port. It owns the memory port while init is low.

Parameters:
MSG_LEN, 41, message bytes at DM[0 : MSG_LEN-1]
PRE_ADDR, 41, address of preamble length
TAP_ADDR, 42, address of LFSR tap pattern
SEED_ADDR, 43, address of LFSR start state
OUT_BASE, 64, first ciphertext address
OUT_LEN, 64, ciphertext bytes written
PAD_CHAR, 8'h20, padding byte (ASCII space)

Ports:
clk  in  1  system clock, all state updates on rising edge
init  in  1  reset/start; synchronous, active-high; the job starts on the first rising edge with init low
mem_addr  out  8  data memory address
mem_rd_en  out  1  read strobe; data valid on mem_rdata one cycle later
mem_rdata  in  8  read data (1-cycle synchronous latency)
mem_wr_en  out  1  write strobe; written at the rising edge
mem_wdata  out  8  write data
done  out  1  job complete; held high until init is asserted

Behaviour:
- Reset (init=1 at an edge):
  - state<=P0; pre, tap, lfsr, idx <= 0.
  - done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
  - mem_wr_en and mem_rd_en are also combinationally gated by !init, so there is no memory access in any cycle where init=1.
- States (cycle k = k-th edge after init falls):
  - P0: rd PRE_ADDR.
  - P1: rd TAP_ADDR; pre<=mem_rdata.
  - P2: rd SEED_ADDR; tap<=mem_rdata.
  - P3: lfsr<=mem_rdata; idx<=0.
  - B_RD: if pad(idx)=0, rd DM[idx-pre]; otherwise no read.
  - B_WR: wr DM[OUT_BASE+idx], data = (pad(idx) ? PAD_CHAR : mem_rdata) ^ lfsr.
    - lfsr<={lfsr[6:0], ^(lfsr & tap)}.
    - idx<=idx+1.
    - Next state is B_RD, or DONE when idx==OUT_LEN-1.
  - DONE: done=1; no memory access; stays in DONE until init.
- Pad rule: pad(idx) = (idx < pre) || (idx - pre >= MSG_LEN). Compute in 9 bits to avoid wrap.
- Truncation: when pre > OUT_LEN-MSG_LEN, message bytes beyond stream index 63 are silently dropped.
- pre >= 64: the output is all PAD_CHAR^lfsr.
- Latency: exactly 4 + 2*OUT_LEN = 132 cycles from init falling to done=1. With defaults done is first high in cycle 132.
- The byte written at idx uses the LFSR state before that edge's step, so byte 0 uses the seed.
- seed=0 is legal: lfsr stays 0 and the output equals the padded plaintext (debug mode).
- tap is not validated; any 8-bit value is accepted.
- Reset mid-operation: init=1 in any state aborts the job with no write in that cycle. Next edge goes to P0, done=0, and partially written output is left as is.
- Outputs are decoded from state/idx. mem_addr = OUT_BASE+idx in B_WR and idx-pre in B_RD; otherwise 0.

Decomposition:
- Package crypt_pkg: state enum (P0, P1, P2, P3, B_RD, B_WR, DONE), PAD_CHAR, default address constants, function lfsr_next(state, tap).
- Sub-module lfsr8: 8-bit register with load (seed) and step enable, tap input, q output. The controller instantiates one.

Test Plan:
- Message "Mr. Watson, come here. I want to see you.", pre=9, tap=8'he1, seed=8'h01. Expected lfsr 01,03,07,0F,1F,3F,7E. DM[64]=8'h21, DM[65]=8'h23, DM[66]=8'h27. DM[73]='M'^lfsr[9]. All 64 bytes match the bench model. done first high at cycle 132.
- pre=23 (last message byte at idx 63) and pre=30 (last 7 message bytes dropped). Expected: no read of DM[34..40] when pre=30; byte 63 correct in both cases.
- seed=0, pre=9, any tap. Expected DM[64+i] = padded plaintext exactly.
- init pulsed high at cycle 60 for 1 cycle. Expected: no write in that cycle, restart from P0, done at 132 cycles after the second fall, final DM correct.
- done holds high for 50 cycles with init low and no memory strobes. Asserting init clears done on the next edge.
